// File: rtl/regfile_pkg.sv
// Shared types and default constants for the multi-port register file.
package regfile_pkg;

   typedef enum logic [1:0] {
      ST_RST,
      ST_CLEAR,
      ST_RUN
   } state_e;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_NUM_WR   = 2;

   localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: write ports, read ports and scoreboard.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR
);
   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_WR-1:0]             we;
   logic [NUM_WR-1:0][AW-1:0]     waddr;
   logic [NUM_WR-1:0][DATA_W-1:0] wdata;
   logic [NUM_RD-1:0]             re;
   logic [NUM_RD-1:0][AW-1:0]     raddr;
   logic [NUM_RD-1:0][DATA_W-1:0] rdata;
   logic                          sb_set;
   logic [AW-1:0]                 sb_addr;
   logic [NUM_RD-1:0]             sb_busy;
   logic                          init_done;

   modport master (
      output we, waddr, wdata, re, raddr, sb_set, sb_addr,
      input  rdata, sb_busy, init_done
   );

   modport slave (
      input  we, waddr, wdata, re, raddr, sb_set, sb_addr,
      output rdata, sb_busy, init_done
   );

endinterface

// File: rtl/regfile_rd_port.sv
// One read port: enable/reg0 gating, same-cycle write bypass, array data and hazard flag.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int AW     = 5,
   parameter int NUM_WR = DEF_NUM_WR
) (
   input  logic                          run_i,
   input  logic                          re_i,
   input  logic [AW-1:0]                 raddr_i,
   input  logic [NUM_WR-1:0]             we_i,
   input  logic [NUM_WR-1:0][AW-1:0]     waddr_i,
   input  logic [NUM_WR-1:0][DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0]             reg_data_i,
   input  logic                          busy_i,
   output logic [DATA_W-1:0]             rdata_o,
   output logic                          sb_busy_o
);
   logic              hit;
   logic [DATA_W-1:0] byp_data;
   logic              active;

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      hit      = 1'b0;
      byp_data = DATA_W'(ZERO_WORD);
      // Ascending scan: the highest-numbered matching write port wins.
      for (int j = 0; j < NUM_WR; j++) begin
         if (we_i[j] && (waddr_i[j] == raddr_i)) begin
            hit      = 1'b1;
            byp_data = wdata_i[j];
         end
      end
   end

   assign active    = run_i && re_i && (raddr_i != '0);
   assign rdata_o   = !active ? DATA_W'(ZERO_WORD) : (hit ? byp_data : reg_data_i);
   assign sb_busy_o = run_i && re_i && busy_i && !hit;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, post-reset zero-clear sequencer and busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   state_e              state_q;
   logic [AW-1:0]       clr_idx_q;
   logic                init_done_q;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                run;
   logic [NUM_WR-1:0]   wr_en;

   assign run   = (state_q == ST_RUN);
   assign wr_en = run ? bus.we : '0;

   // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RST;
         clr_idx_q   <= AW'(1);
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RST: begin
               state_q   <= ST_CLEAR;
               clr_idx_q <= AW'(1);
            end
            ST_CLEAR: begin
               if (clr_idx_q == AW'(NUM_REGS - 1)) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  clr_idx_q <= clr_idx_q + AW'(1);
               end
            end
            ST_RUN:  state_q <= ST_RUN;
            default: state_q <= ST_RST;
         endcase
      end
   end

   // NOTE: the array has no reset; the clear sequencer zeroes it after every reset instead.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         regs_q[clr_idx_q] <= DATA_W'(ZERO_WORD);
      end else if (rst) begin
         // Later ports overwrite earlier ones on an address collision.
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (bus.waddr[j] != '0)) begin
               regs_q[bus.waddr[j]] <= bus.wdata[j];
            end
         end
      end
   end

   // A new producer supersedes a retiring one, so the set is applied after the clears.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en[j]) busy_d[bus.waddr[j]] = 1'b0;
      end
      if (bus.sb_set && (bus.sb_addr != '0)) busy_d[bus.sb_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst || !run) busy_q <= '0;
      else              busy_q <= busy_d;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_rd_port #(
         .DATA_W (DATA_W),
         .AW     (AW),
         .NUM_WR (NUM_WR)
      ) u_rd (
         .run_i      (run),
         .re_i       (bus.re[i]),
         .raddr_i    (bus.raddr[i]),
         .we_i       (wr_en),
         .waddr_i    (bus.waddr),
         .wdata_i    (bus.wdata),
         .reg_data_i (regs_q[bus.raddr[i]]),
         .busy_i     (busy_q[bus.raddr[i]]),
         .rdata_o    (bus.rdata[i]),
         .sb_busy_o  (bus.sb_busy[i])
      );
   end

   assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass, write conflict, reg0, scoreboard race, clear sequence.
module tb_regfile_mp;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   regfile_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) bus ();

   regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.we      = '0;
      bus.waddr   = '0;
      bus.wdata   = '0;
      bus.re      = '0;
      bus.raddr   = '0;
      bus.sb_set  = 1'b0;
      bus.sb_addr = '0;
   endtask

   // Call right after rst is released; inputs already driven stay applied throughout.
   task automatic run_clear(input string tag);
      int cnt;
      step();
      check({tag, " init_done after first edge"}, 32'(bus.init_done), 32'd0);
      check({tag, " rdata0 during clear"}, bus.rdata[0], 32'd0);
      cnt = 0;
      while (cnt < 100) begin
         step();
         cnt++;
         if (bus.init_done) break;
      end
      check({tag, " clear edges"}, 32'(cnt), 32'd31);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle();
      rst = 1'b0;
      bus.re[0]    = 1'b1;
      bus.raddr[0] = 5'd5;
      step();
      step();
      settle();
      check("reset init_done", 32'(bus.init_done), 32'd0);
      check("reset rdata0", bus.rdata[0], 32'd0);
      check("reset sb_busy", 32'(bus.sb_busy), 32'd0);

      rst = 1'b1;
      run_clear("boot");
      idle();

      // Write forwarding
      bus.we[0] = 1'b1; bus.waddr[0] = 5'd5; bus.wdata[0] = 32'hDEADBEEF;
      bus.re[0] = 1'b1; bus.raddr[0] = 5'd5;
      settle();
      check("fwd same cycle", bus.rdata[0], 32'hDEADBEEF);
      step();
      bus.we[0] = 1'b0;
      settle();
      check("fwd registered", bus.rdata[0], 32'hDEADBEEF);

      // Write conflict on reg 7
      bus.we = 2'b11;
      bus.waddr[0] = 5'd7; bus.wdata[0] = 32'h1111;
      bus.waddr[1] = 5'd7; bus.wdata[1] = 32'h2222;
      bus.re = 2'b11; bus.raddr[0] = 5'd7; bus.raddr[1] = 5'd5;
      settle();
      check("conflict bypass", bus.rdata[0], 32'h2222);
      check("port1 reads reg5", bus.rdata[1], 32'hDEADBEEF);
      step();
      idle();
      bus.re = 2'b11; bus.raddr[0] = 5'd7; bus.raddr[1] = 5'd7;
      settle();
      check("conflict stored p0", bus.rdata[0], 32'h2222);
      check("conflict stored p1", bus.rdata[1], 32'h2222);

      // Read disable on port 1, with and without bypass
      bus.re[1] = 1'b0; bus.raddr[1] = 5'd5;
      settle();
      check("re1=0 array", bus.rdata[1], 32'd0);
      bus.we[0] = 1'b1; bus.waddr[0] = 5'd5; bus.wdata[0] = 32'hCAFE0001;
      settle();
      check("re1=0 bypass", bus.rdata[1], 32'd0);
      step();
      idle();

      // Register 0
      bus.we[0] = 1'b1; bus.waddr[0] = 5'd0; bus.wdata[0] = 32'hFFFF;
      bus.re[0] = 1'b1; bus.raddr[0] = 5'd0;
      bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
      settle();
      check("reg0 same cycle", bus.rdata[0], 32'd0);
      step();
      idle();
      bus.re[0] = 1'b1; bus.raddr[0] = 5'd0;
      settle();
      check("reg0 later", bus.rdata[0], 32'd0);
      check("reg0 sb_busy", 32'(bus.sb_busy[0]), 32'd0);

      // Scoreboard race on reg 9
      bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
      bus.re = 2'b01; bus.raddr[0] = 5'd9; bus.raddr[1] = 5'd9;
      settle();
      check("sb before edge", 32'(bus.sb_busy[0]), 32'd0);
      step();
      bus.sb_set = 1'b0;
      settle();
      check("sb set visible", 32'(bus.sb_busy[0]), 32'd1);
      check("sb re1=0 gated", 32'(bus.sb_busy[1]), 32'd0);
      bus.we[0] = 1'b1; bus.waddr[0] = 5'd9; bus.wdata[0] = 32'h99;
      settle();
      check("sb hidden by bypass", 32'(bus.sb_busy[0]), 32'd0);
      check("sb bypass data", bus.rdata[0], 32'h99);
      step();
      bus.we = '0;
      settle();
      check("sb cleared", 32'(bus.sb_busy[0]), 32'd0);
      check("reg9 stored", bus.rdata[0], 32'h99);
      bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
      bus.we[1] = 1'b1; bus.waddr[1] = 5'd9; bus.wdata[1] = 32'hAB;
      step();
      bus.sb_set = 1'b0; bus.we = '0;
      settle();
      check("sb set wins", 32'(bus.sb_busy[0]), 32'd1);
      check("reg9 rewritten", bus.rdata[0], 32'hAB);

      // Clear sequence: fill, reset pulse, dropped writes/sets during clear
      idle();
      for (int k = 1; k < 32; k++) begin
         bus.we[0] = 1'b1; bus.waddr[0] = 5'(k); bus.wdata[0] = 32'hA5A5A5A5;
         step();
      end
      idle();
      bus.re[0] = 1'b1; bus.raddr[0] = 5'd31;
      settle();
      check("fill reg31", bus.rdata[0], 32'hA5A5A5A5);
      bus.sb_set = 1'b1; bus.sb_addr = 5'd12;
      step();
      bus.sb_set = 1'b0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      bus.we[0] = 1'b1; bus.waddr[0] = 5'd3; bus.wdata[0] = 32'h1234;
      bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
      run_clear("pulse");
      idle();
      for (int k = 0; k < 32; k += 2) begin
         bus.re = 2'b11; bus.raddr[0] = 5'(k); bus.raddr[1] = 5'(k + 1);
         settle();
         check($sformatf("cleared reg%0d", k), bus.rdata[0], 32'd0);
         check($sformatf("cleared reg%0d", k + 1), bus.rdata[1], 32'd0);
      end
      bus.raddr[0] = 5'd12; bus.raddr[1] = 5'd4;
      settle();
      check("sb zeroed by reset", 32'(bus.sb_busy[0]), 32'd0);
      check("sb set dropped in clear", 32'(bus.sb_busy[1]), 32'd0);

      // Reset in the middle of clearing
      idle();
      bus.we[0] = 1'b1; bus.waddr[0] = 5'd20; bus.wdata[0] = 32'h77;
      bus.we[1] = 1'b1; bus.waddr[1] = 5'd5;  bus.wdata[1] = 32'h55;
      step();
      idle();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      for (int k = 0; k < 9; k++) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      bus.re[0] = 1'b1; bus.raddr[0] = 5'd20;
      run_clear("midclr");
      idle();
      bus.re = 2'b11; bus.raddr[0] = 5'd20; bus.raddr[1] = 5'd5;
      settle();
      check("midclr reg20", bus.rdata[0], 32'd0);
      check("midclr reg5", bus.rdata[1], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
